// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC/fetch stage with req/ack fetch and valid/ready decode handoff; BRANCH_STATS_EN adds retire/taken counters
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            NextPCSrc,
  input  logic [XLEN-1:0] ALURes,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemAck,
  input  logic [31:0]     IMemRData,
  output logic [31:0]     Inst,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            InstValid,
  input  logic            InstReady,
  output logic            MisalignTrap
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     RetireCnt,
  output logic [31:0]     TakenCnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_REQ, S_VALID} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [31:0]     inst_q;
  logic            trap_q;
  logic            fetch_done, retire, taken, misalign;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Request is forced low while reset is held so the reset-state outputs are quiet.
  always_comb begin
    state_next = state;
    IMemReq    = 1'b0;
    InstValid  = 1'b0;
    fetch_done = 1'b0;
    retire     = 1'b0;
    case (state)
      S_REQ: begin
        IMemReq = ~rst;
        if (IMemAck) begin
          fetch_done = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        InstValid = 1'b1;
        if (InstReady) begin
          retire     = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  assign PCPlus4  = pc_q + XLEN'(4);
  assign taken    = retire & NextPCSrc;
  assign misalign = taken & (ALURes[1:0] != 2'b00);
  assign pc_next  = misalign ? TRAP_PC : (taken ? ALURes : PCPlus4);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= NOP;
      trap_q <= 1'b0;
    end else begin
      trap_q <= misalign;
      if (fetch_done) inst_q <= IMemRData;
      if (retire)     pc_q   <= pc_next;
    end
  end

  assign IMemAddr     = pc_q;
  assign PC           = pc_q;
  assign Inst         = inst_q;
  assign MisalignTrap = trap_q;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      RetireCnt <= 32'd0;
      TakenCnt  <= 32'd0;
    end else begin
      if (retire) RetireCnt <= RetireCnt + 32'd1;
      if (taken)  TakenCnt  <= TakenCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - bench for pc_fetch_unit: per-cycle model compare plus directed literal checks
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        NextPCSrc = 1'b0;
  logic [31:0] ALURes = 32'd0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemRData = 32'd0;
  logic [31:0] Inst;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstValid;
  logic        InstReady = 1'b0;
  logic        MisalignTrap;
`ifdef BRANCH_STATS_EN
  logic [31:0] RetireCnt;
  logic [31:0] TakenCnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .ALURes(ALURes),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRData(IMemRData),
    .Inst(Inst), .PC(PC), .PCPlus4(PCPlus4), .InstValid(InstValid),
    .InstReady(InstReady), .MisalignTrap(MisalignTrap)
`ifdef BRANCH_STATS_EN
    , .RetireCnt(RetireCnt), .TakenCnt(TakenCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one held instruction at a time; a retire picks the next PC.
  logic        m_ok = 1'b0;
  logic        m_have;
  logic [31:0] m_pc, m_inst;
  logic        m_trap;
  logic [31:0] m_ret, m_tkn;

  always @(posedge clk) begin
    if (rst) begin
      m_ok   <= 1'b1;
      m_have <= 1'b0;
      m_pc   <= 32'h0;
      m_inst <= 32'h13;
      m_trap <= 1'b0;
      m_ret  <= 0;
      m_tkn  <= 0;
    end else if (m_ok) begin
      m_trap <= 1'b0;
      if (!m_have) begin
        if (IMemAck) begin
          m_inst <= IMemRData;
          m_have <= 1'b1;
        end
      end else if (InstReady) begin
        m_have <= 1'b0;
        m_ret  <= m_ret + 1;
        if (NextPCSrc) begin
          m_tkn <= m_tkn + 1;
          if (ALURes % 4 != 0) begin
            m_pc   <= 32'h100;
            m_trap <= 1'b1;
          end else begin
            m_pc <= ALURes;
          end
        end else begin
          m_pc <= m_pc + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("IMemReq",      {31'd0, IMemReq},      {31'd0, !m_have && !rst});
      chk("IMemAddr",     IMemAddr,              m_pc);
      chk("PC",           PC,                    m_pc);
      chk("PCPlus4",      PCPlus4,               m_pc + 32'd4);
      chk("Inst",         Inst,                  m_inst);
      chk("InstValid",    {31'd0, InstValid},    {31'd0, m_have});
      chk("MisalignTrap", {31'd0, MisalignTrap}, {31'd0, m_trap});
`ifdef BRANCH_STATS_EN
      chk("RetireCnt",    RetireCnt,             m_ret);
      chk("TakenCnt",     TakenCnt,              m_tkn);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_req_low", {31'd0, IMemReq}, 32'd0);
    rst = 1'b0; IMemAck = 1'b1; IMemRData = 32'h0050_0093;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_inst", Inst, 32'h13);
    chk("rst_valid", {31'd0, InstValid}, 32'd0);
    chk("t1_req", {31'd0, IMemReq}, 32'd1);
    chk("t1_addr", IMemAddr, 32'h0);
    cyc(); IMemAck = 1'b0;
    chk("t1_inst", Inst, 32'h0050_0093);
    chk("t1_pc4", PCPlus4, 32'h4);
    chk("t1_valid", {31'd0, InstValid}, 32'd1);

    InstReady = 1'b1; NextPCSrc = 1'b0; ALURes = 32'h80;
    cyc(); InstReady = 1'b0;
    chk("t2_seq_addr", IMemAddr, 32'h4);
    IMemAck = 1'b1; IMemRData = 32'h1111_1111;
    cyc(); IMemAck = 1'b0;
    InstReady = 1'b1; NextPCSrc = 1'b1; ALURes = 32'h40;
    cyc(); InstReady = 1'b0; NextPCSrc = 1'b0;
    chk("t2_jump_addr", IMemAddr, 32'h40);
`ifdef BRANCH_STATS_EN
    chk("t2_retire_cnt", RetireCnt, 32'd2);
    chk("t2_taken_cnt", TakenCnt, 32'd1);
`endif

    repeat (5) cyc();
    chk("t3_req_held", {31'd0, IMemReq}, 32'd1);
    chk("t3_addr_stable", IMemAddr, 32'h40);
    chk("t3_not_valid", {31'd0, InstValid}, 32'd0);
    IMemAck = 1'b1; IMemRData = 32'h2222_2222;
    cyc(); IMemAck = 1'b0;
    chk("t3_valid", {31'd0, InstValid}, 32'd1);

    IMemAck = 1'b1; ALURes = 32'h80;
    for (int i = 0; i < 3; i++) begin
      NextPCSrc = i[0];
      cyc();
    end
    IMemAck = 1'b0;
    chk("t4_pc_hold", PC, 32'h40);
    chk("t4_inst_hold", Inst, 32'h2222_2222);
    InstReady = 1'b1; NextPCSrc = 1'b0;
    cyc(); InstReady = 1'b0;
    chk("t4_seq_addr", IMemAddr, 32'h44);

    IMemAck = 1'b1; IMemRData = 32'h3333_3333;
    cyc(); IMemAck = 1'b0;
    InstReady = 1'b1; NextPCSrc = 1'b1; ALURes = 32'h42;
    cyc(); InstReady = 1'b0; NextPCSrc = 1'b0;
    chk("t5_trap", {31'd0, MisalignTrap}, 32'd1);
    chk("t5_trap_addr", IMemAddr, 32'h100);
    cyc();
    chk("t5_trap_pulse", {31'd0, MisalignTrap}, 32'd0);

    IMemAck = 1'b1; IMemRData = 32'h4444_4444;
    cyc(); IMemAck = 1'b0;
    InstReady = 1'b1; NextPCSrc = 1'b1; ALURes = 32'h40;
    cyc(); InstReady = 1'b0; NextPCSrc = 1'b0;
    IMemAck = 1'b1; IMemRData = 32'h5555_5555;
    cyc();
    chk("t6_pre_pc", PC, 32'h40);
    rst = 1'b1;
    cyc(); rst = 1'b0; IMemAck = 1'b0;
    chk("t6_pc", PC, 32'h0);
    chk("t6_valid", {31'd0, InstValid}, 32'd0);
    chk("t6_inst", Inst, 32'h13);
`ifdef BRANCH_STATS_EN
    chk("t6_retire_cnt", RetireCnt, 32'd0);
`endif

    IMemAck = 1'b1; IMemRData = 32'h6666_6666;
    cyc(); IMemAck = 1'b0;
    InstReady = 1'b1; NextPCSrc = 1'b1; ALURes = 32'hFFFF_FFFC;
    cyc(); InstReady = 1'b0; NextPCSrc = 1'b0;
    IMemAck = 1'b1;
    cyc(); IMemAck = 1'b0;
    chk("wrap_pc4", PCPlus4, 32'h0);
    InstReady = 1'b1;
    cyc(); InstReady = 1'b0;
    chk("wrap_addr", IMemAddr, 32'h0);
    chk("wrap_no_trap", {31'd0, MisalignTrap}, 32'd0);

    IMemAck = 1'b1; InstReady = 1'b1;
    repeat (4) cyc();
    IMemAck = 1'b0; InstReady = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
